// File: rtl/target_history_printer.sv
// target_history_printer: circular target-coordinate history plus live row,
// streamed as ASCII index/data write strobes into a character screen buffer.
module target_history_printer #(
  parameter int SLOTS      = 3,
  parameter int DIGITS     = 4,
  parameter int ROW_BASE   = 176,
  parameter int ROW_STRIDE = 32,
  parameter int LIVE_BASE  = 116
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [8*DIGITS-1:0]   live_x,
  input  logic [8*DIGITS-1:0]   live_y,
  input  logic                  push,
  input  logic                  clear,
  input  logic                  start,
  output logic [7:0]            char_index,
  output logic [7:0]            char_data,
  output logic                  char_we,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            count
);
  localparam int W = 8*DIGITS;
  localparam int P = 2*DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] r_q, r_d, p_q, p_d, count_q, count_d;
  logic [2:0] wp_q, wp_d;
  logic [W-1:0] hx_q [SLOTS];
  logic [W-1:0] hy_q [SLOTS];
  logic [W-1:0] sx_q, sx_d, sy_q, sy_d, px_q, px_d, py_q, py_d, ux, uy, rx, ry, src;
  logic pp_q, pp_d, pc_q, pc_d, do_push, do_clr, live, valid, we_d, we_q;
  logic [4:0] s5, slot;
  logic [3:0] k, nib;
  logic [7:0] base, idx_d, idx_q, dat_d, dat_q;
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    p_d = p_q;
    sx_d = sx_q;
    sy_d = sy_q;
    px_d = px_q;
    py_d = py_q;
    pp_d = pp_q;
    pc_d = pc_q;
    do_push = 1'b0;
    do_clr = 1'b0;
    ux = live_x;
    uy = live_y;
    case (state_q)
      IDLE: begin
        do_clr = clear;
        do_push = push & ~clear;
        if (start) begin
          state_d = RUN;
          r_d = '0;
          p_d = '0;
          sx_d = live_x;
          sy_d = live_y;
        end
      end
      RUN: begin
        if (r_q == 4'(SLOTS+1)) state_d = DONE;
        else begin
          p_d = (p_q == 4'(P-1)) ? 4'd0 : p_q + 4'd1;
          r_d = (p_q == 4'(P-1)) ? r_q + 4'd1 : r_q;
        end
        // one-deep pending request; the most recent one replaces any earlier
        if (clear) {pc_d, pp_d} = 2'b10;
        else if (push) begin
          {pc_d, pp_d} = 2'b01;
          px_d = live_x;
          py_d = live_y;
        end
      end
      default: begin
        state_d = IDLE;
        do_clr = clear | (pc_q & ~push);
        do_push = ~clear & (push | pp_q);
        ux = push ? live_x : px_q;
        uy = push ? live_y : py_q;
        pp_d = 1'b0;
        pc_d = 1'b0;
      end
    endcase
    wp_d = do_clr ? 3'd0 : do_push ? ((wp_q == 3'(SLOTS-1)) ? 3'd0 : wp_q + 3'd1) : wp_q;
    count_d = do_clr ? 4'd0 : (do_push && count_q != 4'(SLOTS)) ? count_q + 4'd1 : count_q;
  end
  always_comb begin
    live = r_q == 4'(SLOTS);
    s5 = 5'(wp_q) + 5'(SLOTS-1) - 5'(r_q);
    slot = (s5 >= 5'(SLOTS)) ? s5 - 5'(SLOTS) : s5;
    rx = '0;
    ry = '0;
    for (int i = 0; i < SLOTS; i++) if (slot == 5'(i)) begin
      rx = hx_q[i];
      ry = hy_q[i];
    end
    valid = live | (r_q < count_q);
    src = (p_q < 4'(DIGITS)) ? (live ? sx_q : rx) : (live ? sy_q : ry);
    k = (p_q < 4'(DIGITS)) ? 4'(DIGITS-1) - p_q : 4'(P-1) - p_q;
    nib = 4'(src >> {k, 3'b000});
    dat_d = !valid ? 8'h20 : (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    base = live ? 8'(LIVE_BASE) : 8'(ROW_BASE) + 8'(r_q) * 8'(ROW_STRIDE);
    idx_d = base + {4'h0, p_q} + {5'h0, p_q[3:1]};
    we_d = (state_q == RUN) && (r_q != 4'(SLOTS+1));
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      r_q <= '0;
      p_q <= '0;
      wp_q <= '0;
      count_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      px_q <= '0;
      py_q <= '0;
      pp_q <= 1'b0;
      pc_q <= 1'b0;
      we_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      p_q <= p_d;
      wp_q <= wp_d;
      count_q <= count_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      px_q <= px_d;
      py_q <= py_d;
      pp_q <= pp_d;
      pc_q <= pc_d;
      we_q <= we_d;
      idx_q <= idx_d;
      dat_q <= dat_d;
    end
  end
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        hx_q[i] <= '0;
        hy_q[i] <= '0;
      end else if (do_push && wp_q == 3'(i)) begin
        hx_q[i] <= ux;
        hy_q[i] <= uy;
      end
    end
  end
  assign char_index = idx_q;
  assign char_data = dat_q;
  assign char_we = we_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign count = count_q;
endmodule

// File: tb/tb_target_history_printer.sv
// tb_target_history_printer: random passes against a queue-based history model.
module tb_target_history_printer;
  logic clock = 1'b0, resetn = 1'b0;
  always #5 clock = ~clock;
  logic [31:0] live_x = '0, live_y = '0;
  logic [15:0] lx1 = '0, ly1 = '0;
  logic push = 1'b0, clear = 1'b0, start = 1'b0, push1 = 1'b0, clear1 = 1'b0, start1 = 1'b0;
  logic [7:0] ci, cd, ci1, cd1;
  logic we, bz, dn, we1, bz1, dn1;
  logic [3:0] cnt, cnt1;
  logic sel = 1'b0;
  target_history_printer u0 (
    .clock(clock), .resetn(resetn), .live_x(live_x), .live_y(live_y),
    .push(push), .clear(clear), .start(start), .char_index(ci), .char_data(cd),
    .char_we(we), .busy(bz), .done(dn), .count(cnt));
  target_history_printer #(.SLOTS(1), .DIGITS(2)) u1 (
    .clock(clock), .resetn(resetn), .live_x(lx1), .live_y(ly1),
    .push(push1), .clear(clear1), .start(start1), .char_index(ci1), .char_data(cd1),
    .char_we(we1), .busy(bz1), .done(dn1), .count(cnt1));
  logic [7:0] oi, od;
  logic ow, ob, od_n;
  logic [3:0] oc;
  assign oi = sel ? ci1 : ci;
  assign od = sel ? cd1 : cd;
  assign ow = sel ? we1 : we;
  assign ob = sel ? bz1 : bz;
  assign od_n = sel ? dn1 : dn;
  assign oc = sel ? cnt1 : cnt;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mhx[$], mhy[$];
  logic [7:0] exp_i[$], exp_d[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d < 4'd10) ? 8'h30 + 8'(d) : 8'h41 + 8'(d) - 8'd10;
  endfunction
  task automatic mpush(input logic [31:0] x, input logic [31:0] y, input int cap);
    mhx.push_front(x);
    mhy.push_front(y);
    if (mhx.size() > cap) begin
      void'(mhx.pop_back());
      void'(mhy.pop_back());
    end
  endtask
  task automatic mclear();
    mhx.delete();
    mhy.delete();
  endtask
  task automatic build(input int ns, input int nd, input logic [31:0] sx, input logic [31:0] sy);
    int base, k;
    logic [31:0] v;
    exp_i.delete();
    exp_d.delete();
    for (int r = 0; r <= ns; r++)
      for (int p = 0; p < 2*nd; p++) begin
        base = (r == ns) ? 116 : 176 + 32*r;
        k = (p < nd) ? nd-1-p : 2*nd-1-p;
        if (r == ns) v = (p < nd) ? sx : sy;
        else if (r < mhx.size()) v = (p < nd) ? mhx[r] : mhy[r];
        else v = '0;
        exp_i.push_back(8'((base + p + p/2) % 256));
        exp_d.push_back((r < ns && r >= mhx.size()) ? 8'h20 : asc(v[8*k +: 4]));
      end
  endtask
  task automatic setlive(input bit s, input logic [31:0] x, input logic [31:0] y);
    if (s) begin
      lx1 = x[15:0];
      ly1 = y[15:0];
    end else begin
      live_x = x;
      live_y = y;
    end
  endtask
  task automatic setpush(input bit s, input bit v);
    if (s) push1 = v; else push = v;
  endtask
  task automatic setclear(input bit s, input bit v);
    if (s) clear1 = v; else clear = v;
  endtask
  task automatic setstart(input bit s, input bit v);
    if (s) start1 = v; else start = v;
  endtask
  task automatic ipush(input bit s, input logic [31:0] x, input logic [31:0] y, input bit c);
    @(negedge clock);
    setlive(s, x, y);
    setpush(s, 1'b1);
    setclear(s, c);
    @(negedge clock);
    setpush(s, 1'b0);
    setclear(s, 1'b0);
    if (c) mclear();
    else mpush(s ? {16'h0, x[15:0]} : x, s ? {16'h0, y[15:0]} : y, s ? 1 : 3);
  endtask
  task automatic do_pass(input bit s, input logic [31:0] x, input logic [31:0] y, input bit ps, input int mid);
    int ns, nd, nw, n, cyc;
    bit got_done, frozen, pend;
    logic [31:0] qx, qy;
    ns = s ? 1 : 3;
    nd = s ? 2 : 4;
    nw = (ns+1)*2*nd;
    n = 0;
    cyc = 0;
    got_done = 0;
    frozen = 0;
    pend = 0;
    qx = '0;
    qy = '0;
    sel = s;
    @(negedge clock);
    setlive(s, x, y);
    setstart(s, 1'b1);
    setpush(s, ps);
    if (ps) mpush(s ? {16'h0, x[15:0]} : x, s ? {16'h0, y[15:0]} : y, ns);
    build(ns, nd, s ? {16'h0, x[15:0]} : x, s ? {16'h0, y[15:0]} : y);
    @(negedge clock);
    setstart(s, 1'b0);
    setpush(s, 1'b0);
    while (!got_done && cyc < 4*nw) begin
      if (ow) begin
        if (n < nw) begin
          check($sformatf("idx%0d", n), oi, exp_i[n]);
          check($sformatf("dat%0d", n), od, exp_d[n]);
        end
        check("busy_wr", ob, 1);
        n++;
      end
      if (od_n) begin
        got_done = 1;
        check("busy_done", ob, 0);
        check("nwrites", n, nw);
      end
      if (mid == 3 && n == 10) begin
        resetn = 1'b0;
        #1;
        check("rst_we", ow, 0);
        check("rst_idx", oi, 0);
        check("rst_dat", od, 0);
        check("rst_busy", ob, 0);
        check("rst_done", od_n, 0);
        check("rst_cnt", oc, 0);
        @(negedge clock);
        check("rst_nodone", od_n, 0);
        resetn = 1'b1;
        mclear();
        return;
      end
      if (!got_done) begin
        if (mid == 1 && cyc == 5) begin
          qx = $urandom;
          qy = $urandom;
          setlive(s, qx, qy);
          setpush(s, 1'b1);
          frozen = 1;
          pend = 1;
        end else begin
          setpush(s, 1'b0);
          if (!frozen) setlive(s, $urandom, $urandom);
        end
        setstart(s, mid == 2 && cyc == 7);
        cyc++;
        @(negedge clock);
      end
    end
    if (!got_done) check("timeout", 0, 1);
    if (pend) mpush(s ? {16'h0, qx[15:0]} : qx, s ? {16'h0, qy[15:0]} : qy, ns);
    @(negedge clock);
    check("done_1cyc", od_n, 0);
    check("cnt_after", oc, mhx.size());
    for (int i = 0; i < 3; i++) begin
      check("no_extra", ow, 0);
      @(negedge clock);
    end
  endtask
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("r_we", we, 0);
    check("r_idx", ci, 0);
    check("r_dat", cd, 0);
    check("r_busy", bz, 0);
    check("r_done", dn, 0);
    check("r_cnt", cnt, 0);
    check("r_cnt1", cnt1, 0);
    resetn = 1'b1;
    do_pass(0, 32'h01020304, 32'h05060708, 0, 0);
    ipush(0, 32'h00010203, 32'h0A0B0C0D, 0);
    check("cnt1", cnt, 1);
    do_pass(0, $urandom, $urandom, 0, 0);
    for (int i = 0; i < 4; i++) ipush(0, $urandom, $urandom, 0);
    check("cnt_full", cnt, 3);
    do_pass(0, $urandom, $urandom, 0, 0);
    ipush(0, $urandom, $urandom, 1);
    check("push_clr", cnt, 0);
    ipush(0, $urandom, $urandom, 0);
    do_pass(0, $urandom, $urandom, 0, 1);
    do_pass(0, $urandom, $urandom, 0, 2);
    do_pass(0, $urandom, $urandom, 1, 0);
    do_pass(0, $urandom, $urandom, 0, 3);
    do_pass(0, $urandom, $urandom, 0, 0);
    for (int it = 0; it < 10; it++) begin
      int np;
      np = $urandom_range(0, 4);
      for (int j = 0; j < np; j++) ipush(0, $urandom, $urandom, 0);
      if ($urandom_range(0, 3) == 0) ipush(0, $urandom, $urandom, 1);
      do_pass(0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    mclear();
    ipush(1, $urandom, $urandom, 1);
    do_pass(1, 32'h00000102, 32'h00000304, 0, 0);
    for (int j = 0; j < 2; j++) ipush(1, $urandom, $urandom, 0);
    check("u1_cnt", cnt1, 1);
    do_pass(1, $urandom, $urandom, 0, 1);
    do_pass(1, $urandom, $urandom, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
